alu_arbiter: RTL and testbench

Round-robin controller that shares one combinational `alu` instance between two requesters. Each requester hands over an operation (operands plus opcode) with a valid/ready handshake. The arbiter registers the winning operation onto the ALU inputs and captures the ALU result and flags. It returns them on a single response channel tagged with the requester id. It sits between the board-level stimulus sources (switch/debug logic, sequencers) and the ALU, in front of the display path.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Registers the winning operation onto the ALU inputs, then returns a tagged response.
module alu_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,

  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_out,
  input  logic [2:0]   alu_flags,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_out,
  output logic [2:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic [N-1:0] alu_a_q, alu_b_q;
  logic [2:0]   alu_op_q;
  logic         rsp_id_q;
  logic [N-1:0] rsp_out_q;
  logic [2:0]   rsp_flags_q;

  logic         grant0, grant1;
  logic         accept;
  logic         grant_id;

  // Grants are gated by rst_n so the readies read 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign grant_id = grant1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          last_d  = grant_id;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Operand registers hold their last value between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rsp_id_q <= 1'b0;
    end else if (accept) begin
      alu_a_q  <= grant_id ? req1_a  : req0_a;
      alu_b_q  <= grant_id ? req1_b  : req0_b;
      alu_op_q <= grant_id ? req1_op : req0_op;
      rsp_id_q <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else if (state_q == StExec) begin
      rsp_out_q   <= alu_out;
      rsp_flags_q <= alu_flags;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rsp_id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub adder ALU, transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_op, alu_flags;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0] rsp_out;
  logic [2:0]   rsp_flags;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Stub ALU: wrapping add, zero flag in bit 0.
  assign alu_out   = alu_a + alu_b;
  assign alu_flags = {2'b00, alu_out == '0};

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: one in-flight transaction, its age in edges since acceptance,
  // and the values last presented on the ALU and response ports.
  bit m_inflight;
  int m_age;
  bit m_last;
  int m_a, m_b, m_op, m_id, m_out, m_flags;
  int e0, e1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_inflight = 0; m_age = 0; m_last = 1;
      m_a = 0; m_b = 0; m_op = 0; m_id = 0; m_out = 0; m_flags = 0;
      e0 = 0; e1 = 0;
    end else begin
      e0 = 0; e1 = 0;
      if (!m_inflight) begin
        if (req0_valid && req1_valid) begin
          if (m_last) e0 = 1; else e1 = 1;
        end else begin
          e0 = int'(req0_valid);
          e1 = int'(req1_valid);
        end
      end
    end
    chk("req0_ready", int'(req0_ready), e0);
    chk("req1_ready", int'(req1_ready), e1);
    chk("busy", int'(busy), int'(m_inflight));
    chk("rsp_valid", int'(rsp_valid), int'(m_inflight && m_age == 2));
    chk("alu_a", int'(alu_a), m_a);
    chk("alu_b", int'(alu_b), m_b);
    chk("alu_op", int'(alu_op), m_op);
    chk("rsp_id", int'(rsp_id), m_id);
    chk("rsp_out", int'(rsp_out), m_out);
    chk("rsp_flags", int'(rsp_flags), m_flags);
    if (rst_n) begin
      if (!m_inflight) begin
        if (e0 != 0 || e1 != 0) begin
          m_inflight = 1;
          m_age = 1;
          m_id = e1;
          m_last = (e1 != 0);
          m_a  = (e1 != 0) ? int'(req1_a)  : int'(req0_a);
          m_b  = (e1 != 0) ? int'(req1_b)  : int'(req0_b);
          m_op = (e1 != 0) ? int'(req1_op) : int'(req0_op);
        end
      end else if (m_age == 1) begin
        m_age = 2;
        m_out = (m_a + m_b) % (1 << N);
        m_flags = (m_out == 0) ? 1 : 0;
      end else if (rsp_ready) begin
        m_inflight = 0;
      end
    end
  end

  task automatic drive(input int r, input int a, input int b, input int op);
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = N'(a); req0_b = N'(b); req0_op = 3'(op);
    end else begin
      req1_valid = 1'b1; req1_a = N'(a); req1_b = N'(b); req1_op = 3'(op);
    end
  endtask

  // Returns just after the accepting edge.
  task automatic wait_accept(input int r);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (r == 0) got = req0_valid && req0_ready;
      else        got = req1_valid && req1_ready;
    end
    chk($sformatf("accept_req%0d", r), int'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output bit got);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("rsp_arrived", int'(got), 1);
  endtask

  task automatic wait_rsp(input int id, input int out, input int flags);
    bit got;
    wait_valid(got);
    if (got) begin
      chk("lit_rsp_id", int'(rsp_id), id);
      chk("lit_rsp_out", int'(rsp_out), out);
      chk("lit_rsp_flags", int'(rsp_flags), flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_rsp_out", int'(rsp_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  bit a0, a1, got;

  initial begin
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-EXEC drops the operation.
    rsp_ready = 1;
    drive(0, 3, 4, 0);
    wait_accept(0);
    req0_valid = 0;
    chk("exec_busy", int'(busy), 1);
    chk("exec_alu_a", int'(alu_a), 3);
    chk("exec_alu_b", int'(alu_b), 4);
    rst_n = 1'b0;
    #1;
    chk("async_alu_a", int'(alu_a), 0);
    chk("async_alu_b", int'(alu_b), 0);
    chk("async_busy", int'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_rst", int'(rsp_valid), 0);
    end
    @(posedge clk); #1;

    // Single request and wrap with zero flag.
    drive(0, 3, 4, 0);
    wait_accept(0);
    req0_valid = 0;
    wait_rsp(0, 7, 0);
    drive(1, 9, 7, 1);
    wait_accept(1);
    req1_valid = 0;
    wait_rsp(1, 0, 1);

    // Contention after reset: req0 first, then req1.
    do_reset();
    drive(0, 1, 1, 0);
    drive(1, 2, 2, 0);
    wait_accept(0);
    req0_valid = 0;
    wait_rsp(0, 2, 0);
    wait_accept(1);
    req1_valid = 0;
    wait_rsp(1, 4, 0);

    // Both held valid: grants alternate 0,1,0,1.
    drive(0, 2, 3, 0);
    drive(1, 4, 4, 0);
    for (int i = 0; i < 4; i++) begin
      wait_accept(i % 2);
      wait_rsp(i % 2, (i % 2 != 0) ? 8 : 5, 0);
    end
    req0_valid = 0;
    req1_valid = 0;

    // Backpressure: response held stable, pending req1 waits.
    rsp_ready = 0;
    drive(0, 5, 6, 2);
    wait_accept(0);
    req0_valid = 0;
    drive(1, 1, 1, 3);
    wait_valid(got);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_out", int'(rsp_out), 11);
      chk("bp_rsp_id", int'(rsp_id), 0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    wait_accept(1);
    req1_valid = 0;
    wait_rsp(1, 2, 0);

    // Reset while RESP stalls; req0 wins afterwards with last reset to 1.
    rsp_ready = 0;
    drive(1, 1, 2, 0);
    wait_accept(1);
    req1_valid = 0;
    drive(0, 6, 6, 0);
    wait_valid(got);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midwait_rsp_valid", int'(rsp_valid), 0);
    chk("midwait_rsp_out", int'(rsp_out), 0);
    chk("midwait_busy", int'(busy), 0);
    drive(1, 7, 7, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_accept(0);
    req0_valid = 0;
    req1_valid = 0;
    chk("reaccept_alu_a", int'(alu_a), 6);
    rsp_ready = 1;
    wait_rsp(0, 12, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (req0_valid && !a0 && $urandom_range(0, 15) == 0) req0_valid = 0;
      else if (a0 || !req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = N'($urandom); req0_b = N'($urandom); req0_op = 3'($urandom);
      end
      if (req1_valid && !a1 && $urandom_range(0, 15) == 0) req1_valid = 0;
      else if (a1 || !req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = N'($urandom); req1_b = N'($urandom); req1_op = 3'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
